// File: rtl/konwersja_u2_zm_if.sv
// -----------------------------------------------------------------------------
// konwersja_u2_zm_if
//   Operand/result bundle for the two's-complement to sign-magnitude
//   converter slot of the arithmetic unit.
//
//   Signals
//     i_arg_A   operand, two's complement (driven by the operand register side)
//     o_result  result, sign-magnitude: [BITS-1]=sign, [BITS-2:0]=magnitude
//     o_error   1 = operand has no sign-magnitude equivalent
//
//   Modports
//     master  operand source / result consumer
//     slave   the converter itself
// -----------------------------------------------------------------------------
interface konwersja_u2_zm_if #(
  parameter int BITS = 32
);

  logic signed [BITS-1:0] i_arg_A;
  logic        [BITS-1:0] o_result;
  logic                   o_error;

  modport master (
    output i_arg_A,
    input  o_result,
    input  o_error
  );

  modport slave (
    input  i_arg_A,
    output o_result,
    output o_error
  );

endinterface

// File: rtl/konwersja_u2_zm.sv
// -----------------------------------------------------------------------------
// konwersja_u2_zm
//   Registered two's-complement (U2) to sign-magnitude (ZM) converter.
//   One operand accepted per clock, result available one cycle later.
//   The single U2 value without a ZM equivalent (most-negative) is reported
//   on o_error and its result is forced to positive zero.
//
//   Ports
//     i_clk    clock, rising-edge active
//     i_rst_n  reset, asynchronous, active-low; clears result and error
//     bus      konwersja_u2_zm_if.slave
//                i_arg_A  (in)  operand, two's complement
//                o_result (out) sign-magnitude result
//                o_error  (out) operand not representable
// -----------------------------------------------------------------------------
module konwersja_u2_zm #(
  parameter int BITS = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  konwersja_u2_zm_if.slave       bus
);

  localparam int MAG_W = BITS - 1;

  typedef struct packed {
    logic             error;
    logic [BITS-1:0]  result;
  } conv_t;

  // Only the magnitude bits of ~A+1 are needed: the carry into the sign
  // position matters solely for the most-negative operand, which is caught
  // separately, so negating the low BITS-1 bits gives the same magnitude as
  // a full-width negation.
  function automatic conv_t to_sign_mag(input logic signed [BITS-1:0] a);
    conv_t            c;
    logic [MAG_W-1:0] mag;
    logic             is_min;

    c      = '0;
    mag    = ~a[MAG_W-1:0] + MAG_W'(1);
    is_min = a[BITS-1] && (a[MAG_W-1:0] == '0);

    if (!a[BITS-1]) begin
      c.result = a;
    end else if (is_min) begin
      // Magnitude 2^(BITS-1) does not fit; report and emit positive zero.
      c.error  = 1'b1;
      c.result = '0;
    end else begin
      c.result = {1'b1, mag};
    end
    return c;
  endfunction

  logic signed [BITS-1:0] arg_p0;
  conv_t                  conv_p0;
  conv_t                  conv_p1;

  // ---- stage p0: combinational conversion of the incoming operand ----
  assign arg_p0  = bus.i_arg_A;
  assign conv_p0 = to_sign_mag(arg_p0);

  // ---- stage p1: output register ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      conv_p1 <= '0;
    end else begin
      conv_p1 <= conv_p0;
    end
  end

  assign bus.o_result = conv_p1.result;
  assign bus.o_error  = conv_p1.error;

endmodule

// File: tb/tb_konwersja_u2_zm.sv
// -----------------------------------------------------------------------------
// tb_konwersja_u2_zm
//   Self-checking bench for konwersja_u2_zm at BITS=32: reset state, directed
//   boundary operands, then back-to-back random operands with an asynchronous
//   reset pulse between clock edges and a reset held across an edge.
// -----------------------------------------------------------------------------
module tb_konwersja_u2_zm;

  localparam int BITS = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  konwersja_u2_zm_if #(.BITS(BITS)) bus ();

  konwersja_u2_zm #(.BITS(BITS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret the operand as a signed integer and build the
  // sign-magnitude word arithmetically. Returns {error, result}.
  function automatic logic [32:0] model(input logic [31:0] a);
    longint      v;
    longint      m;
    logic [31:0] r;
    v = longint'($signed(a));
    if (v >= 0)
      return {1'b0, a};
    if (v == -64'sd2147483648)
      return {1'b1, 32'd0};
    m = -v;
    r = 32'(m);
    r = r | 32'h8000_0000;
    return {1'b0, r};
  endfunction

  task automatic check_out(input string tag, input logic [32:0] exp);
    check({tag, "_res"}, 64'(bus.o_result), 64'(exp[31:0]));
    check({tag, "_err"}, 64'(bus.o_error), 64'(exp[32]));
  endtask

  // Drive an operand between edges, then check one cycle later.
  task automatic apply(input string tag, input logic [31:0] a);
    @(negedge clk);
    bus.i_arg_A = a;
    @(posedge clk);
    #1;
    check_out(tag, model(a));
  endtask

  logic [31:0] directed [6];
  logic [31:0] a;

  initial begin
    n_checks = 0;
    n_errors = 0;
    directed[0] = 32'h0000_0005;
    directed[1] = 32'hFFFF_FFFF;
    directed[2] = 32'h8000_0000;
    directed[3] = 32'h7FFF_FFFF;
    directed[4] = 32'h8000_0001;
    directed[5] = 32'h0000_0000;

    // Reset held over several edges with a non-zero operand present.
    rst_n       = 1'b0;
    bus.i_arg_A = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 33'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (directed[i]) apply($sformatf("dir%0d", i), directed[i]);

    // Negative zero must never appear across a sweep of negatives.
    for (int i = 0; i < 40; i++) begin
      a = 32'h8000_0000 | 32'($urandom_range(0, 3));
      apply("negz", a);
      if (bus.o_result == 32'h8000_0000) check("neg_zero", 64'(bus.o_result), 64'd0);
    end

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if (i % 37 == 0) a = 32'h8000_0000;
      if (i == 150) begin
        // Asynchronous pulse between edges: outputs must clear at once.
        @(negedge clk);
        bus.i_arg_A = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        check_out("pre_rst", model(32'hFFFF_FFFE));
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 33'd0);
        #1;
        rst_n = 1'b1;
      end
      if (i == 220) begin
        // Reset straddling a rising edge: operand must be discarded.
        @(negedge clk);
        bus.i_arg_A = 32'h1234_5678;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_out("held_rst", 33'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      apply("rand", a);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
